// File: rtl/lfsr_checker.sv
// Purpose: locks onto a Fibonacci LFSR word stream (taps N-1,5,4,3) and flags words that deviate from the prediction.
// Latency: one cycle; every output is registered on the edge that samples the valid word.
// Backpressure: none; a word is accepted on every cycle iValid is high, and idle cycles freeze all state.
module lfsr_checker #(
    parameter int N          = 8,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             iReset,
    input  logic             iValid,
    input  logic [N-1:0]     iData,
    input  logic             iClearErr,
    output logic             oLocked,
    output logic             oMatch,
    output logic             oError,
    output logic [CNT_W-1:0] oErrCount
);

    localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       prev_q, prev_d;
    logic [HIT_W-1:0]   hit_q, hit_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               locked_d, match_d, error_d;
    logic [CNT_W-1:0]   cnt_d;

    logic [N-1:0]       pred;
    logic               data_ok;
    logic               data_zero;
    logic               count_err;

    // Predicted next word from the last reference state, plus input classification.
    always_comb begin
        pred      = {prev_q[N-2:0], prev_q[N-1] ^ prev_q[5] ^ prev_q[4] ^ prev_q[3]};
        data_ok   = (iData == pred);
        data_zero = (iData == '0);
    end

    // Next-state and next-output logic for the HUNT/SYNC/LOCKED tracker.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        hit_d     = hit_q;
        miss_d    = miss_q;
        locked_d  = oLocked;
        match_d   = 1'b0;
        error_d   = 1'b0;
        count_err = 1'b0;

        if (iValid) begin
            case (state_q)
                HUNT: begin
                    // All-zero is the LFSR lockup word and can never seed a valid sequence.
                    if (!data_zero) begin
                        prev_d  = iData;
                        hit_d   = '0;
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (data_ok) begin
                        match_d = 1'b1;
                        prev_d  = iData;
                        hit_d   = hit_q + 1'b1;
                        if (hit_q == HIT_W'(LOCK_COUNT - 1)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            miss_d   = '0;
                        end
                    end else if (data_zero) begin
                        state_d = HUNT;
                    end else begin
                        prev_d = iData;
                        hit_d  = '0;
                    end
                end
                LOCKED: begin
                    if (data_ok) begin
                        match_d = 1'b1;
                        prev_d  = iData;
                        miss_d  = '0;
                    end else begin
                        error_d   = 1'b1;
                        count_err = 1'b1;
                        // Flywheel: advance the predictor on its own so bad data never reseeds it.
                        prev_d    = pred;
                        miss_d    = miss_q + 1'b1;
                        if (miss_q == MISS_W'(LOSS_COUNT - 1)) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d  = HUNT;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    // Saturating error counter; a clear in the same cycle as an error wins.
    always_comb begin
        cnt_d = oErrCount;
        if (iClearErr) begin
            cnt_d = '0;
        end else if (count_err && (oErrCount != '1)) begin
            cnt_d = oErrCount + 1'b1;
        end
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            state_q   <= HUNT;
            prev_q    <= '0;
            hit_q     <= '0;
            miss_q    <= '0;
            oLocked   <= 1'b0;
            oMatch    <= 1'b0;
            oError    <= 1'b0;
            oErrCount <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            oLocked   <= locked_d;
            oMatch    <= match_d;
            oError    <= error_d;
            oErrCount <= cnt_d;
        end
    end

endmodule
